// File: rtl/timer_irq_unit.sv
// timer_irq_unit: memory-mapped down-counting timer with a prescaler and a
// level interrupt. It sits beside data RAM on the core's data-memory port.
// Reads are combinational. Writes land at the clock edge where hit & memwrite.
// nIRQ is a registered, active-low copy of (PEND & IE).
//
// Register window (16 bytes at BASE_ADDR, selected by memaddr[3:2]):
//   0x0 CTRL   : [0] EN, [1] RELOAD, [2] IE, [8 +: PRESC_W] PRESC
//   0x4 LOAD   : reload value
//   0x8 COUNT  : current count (read/write)
//   0xC STATUS : [0] PEND, write-1-to-clear
//
// PRESC_W must not exceed 24 so that PRESC fits inside the 32-bit CTRL word.

module timer_irq_unit #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int          PRESC_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memaddr,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [3:0]  be,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        hit,
    output logic        nIRQ
);

    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_LOAD   = 2'd1;
    localparam logic [1:0] SEL_COUNT  = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic               r_en;
    logic               r_reload;
    logic               r_ie;
    logic [PRESC_W-1:0] r_presc;
    logic [31:0]        r_load;
    logic [31:0]        r_count;
    logic               r_pend;
    logic [PRESC_W-1:0] r_pcnt;
    logic               r_nirq;

    // ------------------------------------------------------------------
    // Address decode and write qualification
    // ------------------------------------------------------------------
    logic [1:0]  w_sel;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_load;
    logic        w_wr_count;
    logic        w_wr_status;
    logic [31:0] w_lane_mask;

    // Reads have no side effects, so the read strobe and byte offset carry no
    // information for this block.
    logic w_unused;
    assign w_unused = ^{memread, memaddr[1:0]};

    assign hit         = (memaddr[31:4] == BASE_ADDR[31:4]);
    assign w_sel       = memaddr[3:2];
    assign w_wr        = hit & memwrite;
    assign w_wr_ctrl   = w_wr && (w_sel == SEL_CTRL);
    assign w_wr_load   = w_wr && (w_sel == SEL_LOAD);
    assign w_wr_count  = w_wr && (w_sel == SEL_COUNT);
    assign w_wr_status = w_wr && (w_sel == SEL_STATUS);

    // Expand the byte enables into a bit mask, one byte lane per enable bit.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
            assign w_lane_mask[8*gi +: 8] = {8{be[gi]}};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read-side views of each register
    // ------------------------------------------------------------------
    logic [31:0] w_ctrl_rd;
    logic [31:0] w_status_rd;

    // Pack the CTRL fields into their bus positions; unused bits read 0.
    always_comb begin
        w_ctrl_rd                = '0;
        w_ctrl_rd[0]             = r_en;
        w_ctrl_rd[1]             = r_reload;
        w_ctrl_rd[2]             = r_ie;
        w_ctrl_rd[8 +: PRESC_W]  = r_presc;
    end

    assign w_status_rd = {31'd0, r_pend};

    // ------------------------------------------------------------------
    // Byte-lane merge of write data with current contents
    // ------------------------------------------------------------------
    logic [31:0] w_ctrl_merged;
    logic [31:0] w_load_merged;
    logic [31:0] w_count_merged;
    logic        w_w1c;

    assign w_ctrl_merged  = (w_ctrl_rd & ~w_lane_mask) | (writedata & w_lane_mask);
    assign w_load_merged  = (r_load    & ~w_lane_mask) | (writedata & w_lane_mask);
    assign w_count_merged = (r_count   & ~w_lane_mask) | (writedata & w_lane_mask);
    // PEND lives in lane 0, so only be[0] can clear it.
    assign w_w1c          = w_wr_status & be[0] & writedata[0];

    // ------------------------------------------------------------------
    // Prescaler tick and expiry detection
    // ------------------------------------------------------------------
    logic w_tick;
    logic w_count_zero;
    logic w_expire;

    assign w_tick       = r_en && (r_pcnt == r_presc);
    assign w_count_zero = (r_count == 32'd0);
    assign w_expire     = w_tick && w_count_zero;

    // ------------------------------------------------------------------
    // Combinational read data
    // ------------------------------------------------------------------
    // Select the addressed register; anything outside the window reads 0.
    always_comb begin
        readdata = '0;
        if (hit) begin
            case (w_sel)
                SEL_CTRL:   readdata = w_ctrl_rd;
                SEL_LOAD:   readdata = r_load;
                SEL_COUNT:  readdata = r_count;
                SEL_STATUS: readdata = w_status_rd;
                default:    readdata = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // CTRL fields: CPU writes win; otherwise a one-shot expiry drops EN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en     <= 1'b0;
            r_reload <= 1'b0;
            r_ie     <= 1'b0;
            r_presc  <= '0;
        end else if (w_wr_ctrl) begin
            r_en     <= w_ctrl_merged[0];
            r_reload <= w_ctrl_merged[1];
            r_ie     <= w_ctrl_merged[2];
            r_presc  <= w_ctrl_merged[8 +: PRESC_W];
        end else if (w_expire && !r_reload) begin
            r_en     <= 1'b0;
        end
    end

    // Prescaler phase: restarts on any CTRL write, free-runs while enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcnt <= '0;
        end else if (w_wr_ctrl) begin
            r_pcnt <= '0;
        end else if (r_en) begin
            if (w_tick) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + PRESC_W'(1);
            end
        end
    end

    // LOAD only changes on a CPU write; an expiry in the same cycle sees the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_load <= '0;
        end else if (w_wr_load) begin
            r_load <= w_load_merged;
        end
    end

    // COUNT: CPU write beats the tick; on a tick, decrement or handle expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= w_count_merged;
        end else if (w_tick) begin
            if (!w_count_zero) begin
                r_count <= r_count - 32'd1;
            end else if (r_reload) begin
                r_count <= r_load;
            end else begin
                r_count <= 32'd0;
            end
        end
    end

    // PEND: expiry sets it, and a set in the same cycle beats a W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= 1'b0;
        end else if (w_expire) begin
            r_pend <= 1'b1;
        end else if (w_w1c) begin
            r_pend <= 1'b0;
        end
    end

    // Interrupt output: registered copy of the masked pending flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_nirq <= 1'b1;
        end else begin
            r_nirq <= ~(r_pend & r_ie);
        end
    end

    assign nIRQ = r_nirq;

endmodule

// File: tb/tb_timer_irq_unit.sv
// Self-checking bench for timer_irq_unit: directed scenarios with fixed
// expected values, followed by random bus traffic compared against a
// transaction-level model of the register file.

module tb_timer_irq_unit;

    localparam logic [31:0] BASE      = 32'hFFFF_0000;
    localparam logic [31:0] CTRL_BITS = 32'h0000_FF07;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] memaddr;
    logic        memwrite;
    logic        memread;
    logic [3:0]  be;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        hit;
    logic        nIRQ;

    int n_assert = 0;
    int n_fail   = 0;

    timer_irq_unit #(
        .BASE_ADDR (BASE),
        .PRESC_W   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memaddr   (memaddr),
        .memwrite  (memwrite),
        .memread   (memread),
        .be        (be),
        .writedata (writedata),
        .readdata  (readdata),
        .hit       (hit),
        .nIRQ      (nIRQ)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: CTRL held as its bus word, the rest as plain values.
    // ------------------------------------------------------------------
    logic [31:0] m_ctrl;
    logic [31:0] m_load;
    logic [31:0] m_count;
    logic        m_pend;
    int          m_phase;   // cycles elapsed in current prescaler period
    logic        m_nirq;

    function automatic logic [31:0] lane_merge(logic [31:0] old_v, logic [31:0] new_v, logic [3:0] lanes);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++)
            if (lanes[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    function automatic logic in_window(logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'd15);
    endfunction

    function automatic logic [31:0] m_read(logic [31:0] a);
        if (!in_window(a)) return 32'd0;
        case ((a - BASE) / 4)
            0:       return m_ctrl;
            1:       return m_load;
            2:       return m_count;
            default: return {31'd0, m_pend};
        endcase
    endfunction

    // Advance the model by one clock edge using the bus inputs present at it.
    task automatic model_edge();
        int          reg_idx;
        logic        wr;
        logic        en;
        logic        expired;
        logic        tick;
        int          presc;
        logic [31:0] c_ctrl;
        logic [31:0] c_load;
        logic [31:0] c_count;
        logic        c_pend;
        if (reset) begin
            m_ctrl = 0; m_load = 0; m_count = 0; m_pend = 0; m_phase = 0; m_nirq = 1;
            return;
        end
        wr      = in_window(memaddr) && memwrite;
        reg_idx = int'((memaddr - BASE) / 4);
        en      = m_ctrl[0];
        presc   = int'(m_ctrl[15:8]);
        tick    = en && (m_phase == presc);
        expired = tick && (m_count == 0);
        c_ctrl = m_ctrl; c_load = m_load; c_count = m_count; c_pend = m_pend;

        m_nirq = !(m_pend && m_ie_of(m_ctrl));

        // Count behaviour on a tick.
        if (tick) begin
            if (m_count != 0)       c_count = m_count - 1;
            else if (m_ctrl[1])     c_count = m_load;
            else                    c_count = 0;
        end
        if (expired) begin
            c_pend = 1;
            if (!m_ctrl[1]) c_ctrl[0] = 1'b0;
        end
        // Prescaler phase.
        if (en) m_phase = tick ? 0 : m_phase + 1;

        // CPU writes override timer activity except that a set PEND stays set.
        if (wr) begin
            case (reg_idx)
                0: begin
                    c_ctrl  = lane_merge(m_ctrl, writedata, be) & CTRL_BITS;
                    m_phase = 0;
                end
                1: c_load  = lane_merge(m_load, writedata, be);
                2: c_count = lane_merge(m_count, writedata, be);
                default: if (be[0] && writedata[0] && !expired) c_pend = 0;
            endcase
        end
        m_ctrl = c_ctrl; m_load = c_load; m_count = c_count; m_pend = c_pend;
    endtask

    function automatic logic m_ie_of(logic [31:0] c);
        return c[2];
    endfunction

    // ------------------------------------------------------------------
    // Bench helpers
    // ------------------------------------------------------------------
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge; model follows the same inputs; settle 1 time unit after.
    task automatic edge1();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic bus_write(logic [31:0] off, logic [3:0] lanes, logic [31:0] data);
        memaddr = BASE + off; memwrite = 1'b1; be = lanes; writedata = data;
        edge1();
        memwrite = 1'b0; be = 4'h0;
        $display("wr  off=%h be=%b data=%h", off, lanes, data);
    endtask

    task automatic rd_check(logic [31:0] off, logic [31:0] exp, string tag);
        memaddr = BASE + off; memwrite = 1'b0; be = 4'h0;
        #1;
        $display("rd  off=%h data=%h exp=%h (%s)", off, readdata, exp, tag);
        chk(tag, readdata, exp);
        chk({tag, "_model"}, readdata, m_read(memaddr));
    endtask

    task automatic irq_check(logic exp, string tag);
        $display("irq nIRQ=%b exp=%b (%s)", nIRQ, exp, tag);
        chk(tag, {31'd0, nIRQ}, {31'd0, exp});
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        reset = 1'b1; memaddr = 32'd0; memwrite = 1'b0; memread = 1'b0;
        be = 4'h0; writedata = 32'd0;
        m_ctrl = 0; m_load = 0; m_count = 0; m_pend = 0; m_phase = 0; m_nirq = 1;
        edge1(); edge1();
        reset = 1'b0;

        // Reset state.
        rd_check(32'h0, 32'h0, "rst_ctrl");
        rd_check(32'h4, 32'h0, "rst_load");
        rd_check(32'h8, 32'h0, "rst_count");
        rd_check(32'hC, 32'h0, "rst_status");
        irq_check(1'b1, "rst_nirq");
        memaddr = 32'h1000_0000; #1;
        chk("miss_hit", {31'd0, hit}, 32'd0);
        chk("miss_data", readdata, 32'd0);

        // Byte enables on LOAD.
        bus_write(32'h4, 4'b1111, 32'hAABB_CCDD);
        bus_write(32'h4, 4'b0101, 32'h1122_3344);
        rd_check(32'h4, 32'hAA22_CC44, "be_merge");
        bus_write(32'h4, 4'b0000, 32'hFFFF_FFFF);
        rd_check(32'h4, 32'hAA22_CC44, "be_none");

        // Periodic mode, PRESC=0.
        bus_write(32'h4, 4'hF, 32'd3);
        bus_write(32'h8, 4'hF, 32'd3);
        bus_write(32'h0, 4'hF, 32'h007);            // E0
        edge1(); rd_check(32'h8, 32'd2, "per_e1");
        edge1(); rd_check(32'h8, 32'd1, "per_e2");
        edge1(); rd_check(32'h8, 32'd0, "per_e3");
        edge1();                                    // E4: expiry
        rd_check(32'hC, 32'd1, "per_pend_e4");
        rd_check(32'h8, 32'd3, "per_reload_e4");
        irq_check(1'b1, "per_nirq_e4");
        edge1();                                    // E5
        irq_check(1'b0, "per_nirq_e5");
        bus_write(32'hC, 4'b0001, 32'd1);           // E6: clear PEND
        rd_check(32'hC, 32'd0, "per_w1c_e6");
        edge1();                                    // E7
        irq_check(1'b1, "per_nirq_e7");
        rd_check(32'hC, 32'd0, "per_pend_e7");
        edge1();                                    // E8: expiry again
        rd_check(32'hC, 32'd1, "per_pend_e8");

        // Collisions: W1C on the expiry edge, then COUNT write on a tick edge.
        bus_write(32'h0, 4'hF, 32'h0);
        bus_write(32'hC, 4'h1, 32'h1);
        bus_write(32'h8, 4'hF, 32'd1);
        bus_write(32'h0, 4'hF, 32'h007);            // E0
        edge1();                                    // E1: count 0
        bus_write(32'hC, 4'h1, 32'h1);              // E2: expiry + W1C
        rd_check(32'hC, 32'd1, "col_w1c");
        rd_check(32'h8, 32'd3, "col_reload");
        bus_write(32'h8, 4'hF, 32'h10);             // E3: tick + write
        rd_check(32'h8, 32'h10, "col_count_wr");
        edge1();
        rd_check(32'h8, 32'h0F, "col_count_dec");

        // One-shot mode.
        bus_write(32'h0, 4'hF, 32'h0);
        bus_write(32'hC, 4'h1, 32'h1);
        bus_write(32'h8, 4'hF, 32'd2);
        bus_write(32'h0, 4'hF, 32'h005);            // E0
        edge1(); edge1();
        rd_check(32'hC, 32'd0, "os_pend_e2");
        edge1();                                    // E3: expiry
        rd_check(32'hC, 32'd1, "os_pend_e3");
        rd_check(32'h0, 32'h004, "os_en_clr");
        rd_check(32'h8, 32'd0, "os_count");
        bus_write(32'hC, 4'h1, 32'h1);
        edge1(); edge1(); edge1(); edge1();
        rd_check(32'hC, 32'd0, "os_no_repend");
        rd_check(32'h8, 32'd0, "os_count_hold");

        // CTRL write with EN=1 on a one-shot expiry edge keeps EN set.
        bus_write(32'h0, 4'hF, 32'h005);            // E0, COUNT already 0
        bus_write(32'h0, 4'hF, 32'h005);            // E1: expiry + CTRL write
        rd_check(32'h0, 32'h005, "col_ctrl_en");
        edge1();                                    // E2: expiry, one-shot clears EN
        rd_check(32'h0, 32'h004, "col_ctrl_next");

        // Prescaler: PRESC=3, COUNT=1 => PEND 8 cycles after CTRL write.
        bus_write(32'h0, 4'hF, 32'h0);
        bus_write(32'hC, 4'h1, 32'h1);
        bus_write(32'h8, 4'hF, 32'd1);
        bus_write(32'h0, 4'hF, 32'h305);            // E0
        for (int i = 0; i < 7; i++) edge1();
        rd_check(32'hC, 32'd0, "presc_e7");
        edge1();
        rd_check(32'hC, 32'd1, "presc_e8");

        // Reset in the middle of a count.
        bus_write(32'h8, 4'hF, 32'd5);
        bus_write(32'h0, 4'hF, 32'h007);
        edge1(); edge1();
        reset = 1'b1; edge1(); reset = 1'b0;
        rd_check(32'h0, 32'h0, "mid_rst_ctrl");
        rd_check(32'h8, 32'h0, "mid_rst_count");
        rd_check(32'hC, 32'h0, "mid_rst_status");
        irq_check(1'b1, "mid_rst_nirq");

        // Random bus traffic against the model.
        for (int it = 0; it < 600; it++) begin
            int off;
            off = int'($urandom_range(0, 3));
            reset    = ($urandom_range(0, 99) == 0);
            memaddr  = ($urandom_range(0, 7) == 0) ? $urandom : BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
            memwrite = ($urandom_range(0, 2) == 0);
            be       = 4'($urandom);
            case (off)
                0:       writedata = ($urandom & 32'hFFFF_0007) | (32'($urandom_range(0, 3)) << 8);
                1, 2:    writedata = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 6));
                default: writedata = $urandom;
            endcase
            #1;
            $display("rnd it=%0d addr=%h we=%b be=%b wd=%h rd=%h exp=%h", it, memaddr, memwrite, be, writedata, readdata, m_read(memaddr));
            chk("rnd_hit", {31'd0, hit}, {31'd0, in_window(memaddr)});
            chk("rnd_rdata", readdata, m_read(memaddr));
            edge1();
            chk("rnd_nirq", {31'd0, nIRQ}, {31'd0, m_nirq});
        end
        reset = 1'b0; memwrite = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
